// File: rtl/huffman_pkg.sv
// huffman_pkg
// Shared constants, types and the code-table lookup for the static-Huffman
// byte encoder (huffman_enc).
//
// Contents:
//   BUF_W / FILL_W      bit buffer width and fill counter width
//   MAX_CODE_LEN        longest code (escape prefix + 8 literal bits)
//   READY_MAX_FILL      largest pre-emit fill that still accepts a symbol
//   ESC_CODE / ESC_LEN  escape prefix for symbols not in the table
//   SYM_* / CODE_* / LEN_*  the eight listed symbols and their codes
//   code_t              {left-justified code, length}
//   huff_lookup()       symbol -> code_t, including the escape path
package huffman_pkg;

    localparam int BUF_W          = 24;
    localparam int FILL_W         = 5;
    localparam int MAX_CODE_LEN   = 11;
    localparam int LEN_W          = 4;
    localparam int READY_MAX_FILL = 13;

    localparam logic [2:0] ESC_CODE = 3'b111;
    localparam int         ESC_LEN  = 3;

    // Listed symbols
    localparam logic [7:0] SYM_E = 8'h65;
    localparam logic [7:0] SYM_A = 8'h61;
    localparam logic [7:0] SYM_D = 8'h64;
    localparam logic [7:0] SYM_B = 8'h62;
    localparam logic [7:0] SYM_C = 8'h63;
    localparam logic [7:0] SYM_F = 8'h66;
    localparam logic [7:0] SYM_G = 8'h67;
    localparam logic [7:0] SYM_H = 8'h68;

    // Codes, right-justified in their natural width; first-sent bit is MSB
    localparam logic [1:0] CODE_E = 2'b00;
    localparam logic [2:0] CODE_A = 3'b010;
    localparam logic [2:0] CODE_D = 3'b011;
    localparam logic [2:0] CODE_B = 3'b100;
    localparam logic [3:0] CODE_C = 4'b1010;
    localparam logic [3:0] CODE_F = 4'b1011;
    localparam logic [3:0] CODE_G = 4'b1100;
    localparam logic [3:0] CODE_H = 4'b1101;

    localparam logic [LEN_W-1:0] LEN_E   = 4'd2;
    localparam logic [LEN_W-1:0] LEN_ADB = 4'd3;
    localparam logic [LEN_W-1:0] LEN_CFGH = 4'd4;
    localparam logic [LEN_W-1:0] LEN_LIT = 4'(ESC_LEN + 8);

    typedef struct packed {
        logic [MAX_CODE_LEN-1:0] code;  // left-justified, unused LSBs zero
        logic [LEN_W-1:0]        len;
    } code_t;

    // Unused low bits of every code are zero; the append path ORs the
    // shifted code into the buffer and relies on that.
    function automatic code_t huff_lookup(input logic [7:0] sym);
        code_t r;
        case (sym)
            SYM_E:   begin r.code = {CODE_E, 9'b0}; r.len = LEN_E;    end
            SYM_A:   begin r.code = {CODE_A, 8'b0}; r.len = LEN_ADB;  end
            SYM_D:   begin r.code = {CODE_D, 8'b0}; r.len = LEN_ADB;  end
            SYM_B:   begin r.code = {CODE_B, 8'b0}; r.len = LEN_ADB;  end
            SYM_C:   begin r.code = {CODE_C, 7'b0}; r.len = LEN_CFGH; end
            SYM_F:   begin r.code = {CODE_F, 7'b0}; r.len = LEN_CFGH; end
            SYM_G:   begin r.code = {CODE_G, 7'b0}; r.len = LEN_CFGH; end
            SYM_H:   begin r.code = {CODE_H, 7'b0}; r.len = LEN_CFGH; end
            default: begin r.code = {ESC_CODE, sym}; r.len = LEN_LIT; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/huffman_code_rom.sv
// huffman_code_rom
// Combinational symbol-to-code map. Listed symbols get their short prefix
// code; every other byte gets the escape prefix followed by its 8 literal
// bits.
//
// Ports:
//   data_in  in  8   symbol
//   code     out 11  code bits, left-justified (bit 10 sent first)
//   len      out 4   number of valid code bits (2..11)
module huffman_code_rom
    import huffman_pkg::*;
(
    input  logic [7:0]              data_in,
    output logic [MAX_CODE_LEN-1:0] code,
    output logic [LEN_W-1:0]        len
);

    code_t entry;

    assign entry = huff_lookup(data_in);
    assign code  = entry.code;
    assign len   = entry.len;

endmodule

// File: rtl/huffman_enc.sv
// huffman_enc
// Streaming static-Huffman byte encoder. Accepts one symbol per cycle while
// in_ready is high, packs its code MSB-first into a 24-bit left-justified
// bit buffer, and emits a byte whenever at least 8 bits are buffered.
//
// Ports:
//   clk         in   1  clock, rising edge
//   rst         in   1  synchronous active-high reset
//   enable      in   1  symbol valid; consumed when enable && in_ready
//   data_in     in   8  symbol
//   data_out    out  8  last emitted byte, earliest stream bit in bit 7
//   data_valid  out  1  registered one-cycle pulse per new data_out
//   in_ready    out  1  combinational, high while fill_q <= 13
//
// Optional feature (macro HUFF_FLUSH_EN): when enable falls, residual bits
// are zero-padded to a full byte and emitted. Without the macro, residual
// bits stay buffered and lead the next burst.
module huffman_enc
    import huffman_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       in_ready
);

    logic [BUF_W-1:0]        buf_q, buf_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [7:0]              data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;

    logic [MAX_CODE_LEN-1:0] code;
    logic [LEN_W-1:0]        len;

    logic                    accept;
    logic                    emit;
    logic [BUF_W-1:0]        buf_e;     // buffer after the emit step
    logic [FILL_W-1:0]       fill_e;    // fill after the emit step
    logic [BUF_W-1:0]        code_ext;  // code aligned behind the residual bits

`ifdef HUFF_FLUSH_EN
    logic en_last_q, en_last_d;         // previous-cycle enable
    logic flush_pend_q, flush_pend_d;   // enable fell while >= 8 bits remained
`endif

    huffman_code_rom u_rom (
        .data_in (data_in),
        .code    (code),
        .len     (len)
    );

    // fill_q <= 13 guarantees room: after any emit at most 13 bits remain
    // and the longest code is 11, so the buffer never exceeds 24.
    assign in_ready = (fill_q <= FILL_W'(READY_MAX_FILL));

    always_comb begin
        accept = enable && in_ready;
        emit   = (fill_q >= FILL_W'(8));

        buf_e  = emit ? {buf_q[BUF_W-9:0], 8'h00} : buf_q;
        fill_e = emit ? (fill_q - FILL_W'(8)) : fill_q;

        code_ext = {code, {(BUF_W-MAX_CODE_LEN){1'b0}}} >> fill_e;

        buf_d  = accept ? (buf_e | code_ext) : buf_e;
        fill_d = accept ? (fill_e + FILL_W'(len)) : fill_e;

        data_out_d   = emit ? buf_q[BUF_W-1 -: 8] : data_out_q;
        data_valid_d = emit;

`ifdef HUFF_FLUSH_EN
        en_last_d    = enable;
        flush_pend_d = 1'b0;
        // Bits below the fill are always zero, so padding is just rounding
        // the fill up to 8; the normal emit path sends the byte next edge.
        // If a full byte is still queued, keep waiting until it drains.
        if (!enable && (en_last_q || flush_pend_q)) begin
            if (fill_e >= FILL_W'(8)) begin
                flush_pend_d = 1'b1;
            end else if (fill_e != '0) begin
                fill_d = FILL_W'(8);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q        <= '0;
            fill_q       <= '0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
`ifdef HUFF_FLUSH_EN
            en_last_q    <= 1'b0;
            flush_pend_q <= 1'b0;
`endif
        end else begin
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
`ifdef HUFF_FLUSH_EN
            en_last_q    <= en_last_d;
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_huffman_enc.sv
module tb_huffman_enc;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       in_ready;

    int checks = 0;
    int errors = 0;

    huffman_enc dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .in_ready   (in_ready)
    );

    always #5 clk = ~clk;

    // Reference model: the encoded stream as a plain queue of bits.
    bit         mq[$];
    logic [7:0] m_dout;
    logic       m_dv;
    bit         m_en_last;
    bit         m_pend;
    logic [7:0] got[$];
    bit         saw_not_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [10:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mq.push_back(v[i]);
    endtask

    task automatic push_code(input logic [7:0] s);
        case (s)
            8'h65:   push_bits(11'b00, 2);
            8'h61:   push_bits(11'b010, 3);
            8'h64:   push_bits(11'b011, 3);
            8'h62:   push_bits(11'b100, 3);
            8'h63:   push_bits(11'b1010, 4);
            8'h66:   push_bits(11'b1011, 4);
            8'h67:   push_bits(11'b1100, 4);
            8'h68:   push_bits(11'b1101, 4);
            default: push_bits({3'b111, s}, 11);
        endcase
    endtask

    // Model step at each edge, then compare once outputs have settled.
    always @(posedge clk) begin
        bit rdy;
        if (rst) begin
            mq.delete();
            m_dout    = 8'h00;
            m_dv      = 1'b0;
            m_en_last = 1'b0;
            m_pend    = 1'b0;
        end else begin
            rdy  = (mq.size() <= 13);
            m_dv = 1'b0;
            if (mq.size() >= 8) begin
                for (int i = 0; i < 8; i++) m_dout = {m_dout[6:0], mq.pop_front()};
                m_dv = 1'b1;
            end
            if (enable && rdy) push_code(data_in);
`ifdef HUFF_FLUSH_EN
            if (!enable && (m_en_last || m_pend)) begin
                if (mq.size() < 8) begin
                    while (mq.size() % 8 != 0) mq.push_back(1'b0);
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else begin
                m_pend = 1'b0;
            end
`endif
            m_en_last = enable;
        end
        #1;
        chk("data_valid", {31'b0, data_valid}, {31'b0, m_dv});
        chk("data_out", {24'b0, data_out}, {24'b0, m_dout});
        chk("in_ready", {31'b0, in_ready}, {31'b0, (mq.size() <= 13)});
        if (data_valid) got.push_back(data_out);
        if (!in_ready) saw_not_ready = 1'b1;
    end

    task automatic step(input logic en, input logic [7:0] d);
        @(negedge clk);
        enable  = en;
        data_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] tbl[8] = '{8'h65, 8'h61, 8'h64, 8'h62, 8'h63, 8'h66, 8'h67, 8'h68};
    logic [10:0] esc_pat;
    logic [7:0]  eb;
    int          bi;

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        data_in = 8'h00;
        saw_not_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset data_out", {24'b0, data_out}, 32'h00);
        chk("reset data_valid", {31'b0, data_valid}, 32'h0);
        chk("reset in_ready", {31'b0, in_ready}, 32'h1);
        rst = 1'b0;

        // Single escape symbol 0x6A = 111 01101010
        got.delete();
        step(1'b1, 8'h6A);
        idle(5);
`ifdef HUFF_FLUSH_EN
        chk("esc bytes", got.size(), 2);
        if (got.size() >= 2) chk("esc byte1", {24'b0, got[1]}, 32'h40);
`else
        chk("esc bytes", got.size(), 1);
`endif
        if (got.size() >= 1) chk("esc byte0", {24'b0, got[0]}, 32'hED);

        // a d b = 010 011 100
        do_reset(2);
        got.delete();
        step(1'b1, 8'h61);
        step(1'b1, 8'h64);
        step(1'b1, 8'h62);
        idle(5);
`ifdef HUFF_FLUSH_EN
        chk("adb bytes", got.size(), 2);
        if (got.size() >= 2) chk("adb byte1", {24'b0, got[1]}, 32'h00);
`else
        chk("adb bytes", got.size(), 1);
`endif
        if (got.size() >= 1) chk("adb byte0", {24'b0, got[0]}, 32'h4E);

        // e x4 = exactly one zero byte
        do_reset(2);
        got.delete();
        repeat (4) step(1'b1, 8'h65);
        idle(6);
        chk("eeee bytes", got.size(), 1);
        if (got.size() >= 1) chk("eeee byte0", {24'b0, got[0]}, 32'h00);

        // Sustained escape stream: back-pressure and gapless pattern
        do_reset(2);
        got.delete();
        saw_not_ready = 1'b0;
        repeat (40) step(1'b1, 8'h70);
        idle(6);
        chk("esc stream stalled", {31'b0, saw_not_ready}, 32'h1);
        chk("esc stream enough bytes", {31'b0, (got.size() >= 30)}, 32'h1);
        esc_pat = 11'b111_01110000;
        bi = 0;
        foreach (got[j]) begin
            for (int k = 0; k < 8; k++) begin
                eb[7-k] = esc_pat[10 - (bi % 11)];
                bi++;
            end
`ifdef HUFF_FLUSH_EN
            // Final flushed byte is zero-padded past the stream end
            if (j == got.size() - 1) continue;
`endif
            chk("esc stream byte", {24'b0, got[j]}, {24'b0, eb});
        end

        // Reset with 5 bits buffered discards them
        do_reset(2);
        step(1'b1, 8'h65);
        step(1'b1, 8'h64);
        got.delete();
        do_reset(2);
        chk("midreset no pulse", got.size(), 0);
        step(1'b1, 8'h6A);
        idle(3);
        chk("midreset first byte count", {31'b0, (got.size() >= 1)}, 32'h1);
        if (got.size() >= 1) chk("midreset first byte", {24'b0, got[0]}, 32'hED);

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 299) == 0);
            enable  = ($urandom_range(0, 9) < 7);
            data_in = ($urandom_range(0, 9) < 6) ? tbl[$urandom_range(0, 7)] : 8'($urandom);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
